// File: rtl/float_discriminant_result_buffer_if.sv
// Handshake bundle between the discriminant datapath, the result buffer and its consumer.
// The buffer takes the slave modport; the producer/consumer side takes the master modport.
interface float_discriminant_result_buffer_if #(
  parameter int FLEN = 64
);
  logic            in_vld;
  logic [FLEN-1:0] in_res;
  logic            in_negative;
  logic            in_err;
  logic            in_afull;
  logic            out_vld;
  logic            out_rdy;
  logic [FLEN-1:0] out_res;
  logic            out_negative;
  logic            out_err;

  modport master (
    output in_vld, in_res, in_negative, in_err, out_rdy,
    input  in_afull, out_vld, out_res, out_negative, out_err
  );

  modport slave (
    input  in_vld, in_res, in_negative, in_err, out_rdy,
    output in_afull, out_vld, out_res, out_negative, out_err
  );
endinterface

// File: rtl/float_discriminant_result_buffer.sv
// Small FIFO capturing every discriminant result or error, with an almost-full throttle
// sized so results still in flight through the upstream pipeline always fit.
module float_discriminant_result_buffer #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 8,
  parameter int SLACK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  float_discriminant_result_buffer_if.slave bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              err_cnt,
  output logic                     busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = FLEN + 2;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - SLACK);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            wr, rd, full, wr_acc, head_vld;
  logic [EW-1:0]   wr_entry, head;

  // An error entry discards the datapath's result and sign, which are meaningless then.
  always_comb begin
    wr       = bus.in_vld | bus.in_err;
    wr_entry = bus.in_err ? {1'b1, 1'b0, {FLEN{1'b0}}}
                          : {1'b0, bus.in_negative, bus.in_res};
    head_vld = (count_q != '0);
    full     = (count_q == FULL_LVL);
    rd       = head_vld & bus.out_rdy;
    wr_acc   = wr & (~full | rd);
  end

  always_comb begin
    wp_d       = wr_acc ? wp_q + 1'b1 : wp_q;
    rp_d       = rd ? rp_q + 1'b1 : rp_q;
    count_d    = count_q + CW'(wr_acc) - CW'(rd);
    overflow_d = overflow_q | (wr & ~wr_acc);
    err_cnt_d  = err_cnt_q;
    if (wr_acc && bus.in_err && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wp_q] <= wr_entry;
    end
  end

  always_comb begin
    head             = head_vld ? mem_q[rp_q] : '0;
    bus.out_vld      = head_vld;
    bus.out_res      = head[FLEN-1:0];
    bus.out_negative = head[FLEN];
    bus.out_err      = head[FLEN+1];
    bus.in_afull     = (count_q >= AFULL_LVL);
    count            = count_q;
    overflow         = overflow_q;
    err_cnt          = err_cnt_q;
    busy             = head_vld;
  end
endmodule
